// File: rtl/sm2tc_pkg.sv
// sm2tc shared types and helpers
// widths, clamp limits, lane slicing
package sm2tc_pkg;

  function automatic int ext_width(int mag_w, int sh_w);
    return mag_w + (1 << sh_w) - 1;
  endfunction

  function automatic int cmp_width(int ext_w, int out_w);
    return ((ext_w > out_w) ? ext_w : out_w) + 1;
  endfunction

  function automatic longint sat_max(int out_w);
    return (longint'(1) << (out_w - 1)) - 1;
  endfunction

  function automatic longint sat_min_mag(int out_w);
    return longint'(1) << (out_w - 1);
  endfunction

  function automatic int lane_lsb(int lane, int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/sm2tc_if.sv
// sm2tc stream bundle
// input beat side and output beat side
interface sm2tc_if #(
  parameter int N_CH  = 2,
  parameter int MAG_W = 10,
  parameter int OUT_W = 12,
  parameter int SH_W  = 2
);
  logic                    s_valid;
  logic                    s_ready;
  logic [N_CH*MAG_W-1:0]   s_mag;
  logic [N_CH-1:0]         s_sign;
  logic [SH_W-1:0]         shift_amt;
  logic                    m_valid;
  logic                    m_ready;
  logic [N_CH*OUT_W-1:0]   m_data;
  logic [N_CH-1:0]         m_sat;

  modport master (
    output s_valid, s_mag, s_sign, shift_amt, m_ready,
    input  s_ready, m_valid, m_data, m_sat
  );

  modport slave (
    input  s_valid, s_mag, s_sign, shift_amt, m_ready,
    output s_ready, m_valid, m_data, m_sat
  );
endinterface

// File: rtl/sm2tc_lane.sv
// sm2tc single lane datapath
// front: shift + ovf; back: negate/clamp
module sm2tc_lane
  import sm2tc_pkg::*;
#(
  parameter int MAG_W = 10,
  parameter int OUT_W = 12,
  parameter int SH_W  = 2,
  localparam int EXT_W = ext_width(MAG_W, SH_W)
) (
  input  logic [MAG_W-1:0] mag,
  input  logic             sign,
  input  logic [SH_W-1:0]  shamt,
  output logic [EXT_W-1:0] ext,
  output logic             ovf,
  input  logic [EXT_W-1:0] r_ext,
  input  logic             r_sign,
  input  logic             r_ovf,
  output logic [OUT_W-1:0] res
);
  localparam int CW = cmp_width(EXT_W, OUT_W);
  localparam logic [CW-1:0] LIM_P =
    CW'(sat_max(OUT_W));
  localparam logic [CW-1:0] LIM_N =
    CW'(sat_min_mag(OUT_W));
  localparam logic [OUT_W-1:0] MAX_V =
    OUT_W'(sat_max(OUT_W));
  localparam logic [OUT_W-1:0] MIN_V =
    OUT_W'(sat_min_mag(OUT_W));

  logic [CW-1:0]    ext_c;
  logic [OUT_W-1:0] r_lo;

  // widen, shift and compare against the signed limit
  always_comb begin
    ext   = EXT_W'(mag) << shamt;
    ext_c = CW'(ext);
    ovf   = sign ? (ext_c > LIM_N)
                 : (ext_c > LIM_P);
  end

  // clamp or two's-complement the registered magnitude
  always_comb begin
    r_lo = OUT_W'(CW'(r_ext));
    res  = r_lo;
    unique case (1'b1)
      r_ovf && r_sign:   res = MIN_V;
      r_ovf && !r_sign:  res = MAX_V;
      !r_ovf && r_sign:  res = ~r_lo + OUT_W'(1);
      default:           res = r_lo;
    endcase
  end
endmodule

// File: rtl/sm2tc_pipe.sv
// sm2tc two-stage converter top
// lanes, stage regs, handshake, sat counter
module sm2tc_pipe
  import sm2tc_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int MAG_W = 10,
  parameter int OUT_W = 12,
  parameter int SH_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  sm2tc_if.slave           io,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);
  localparam int EXT_W = ext_width(MAG_W, SH_W);

  logic s1_valid;
  logic s2_valid;
  logic s1_en;
  logic s2_en;

  logic [EXT_W-1:0]      c_ext  [N_CH];
  logic [N_CH-1:0]       c_ovf;
  logic [EXT_W-1:0]      s1_ext [N_CH];
  logic [N_CH-1:0]       s1_sign;
  logic [N_CH-1:0]       s1_ovf;
  logic [N_CH*OUT_W-1:0] d_nxt;
  logic [N_CH*OUT_W-1:0] s2_data;
  logic [N_CH-1:0]       s2_sat;

  assign s2_en      = !s2_valid || io.m_ready;
  assign s1_en      = !s1_valid || s2_en;
  assign io.s_ready = s1_en;
  assign io.m_valid = s2_valid;
  assign io.m_data  = s2_data;
  assign io.m_sat   = s2_sat;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    localparam int ML = lane_lsb(g, MAG_W);
    localparam int OL = lane_lsb(g, OUT_W);
    sm2tc_lane #(
      .MAG_W (MAG_W),
      .OUT_W (OUT_W),
      .SH_W  (SH_W)
    ) u_lane (
      .mag    (io.s_mag[ML +: MAG_W]),
      .sign   (io.s_sign[g]),
      .shamt  (io.shift_amt),
      .ext    (c_ext[g]),
      .ovf    (c_ovf[g]),
      .r_ext  (s1_ext[g]),
      .r_sign (s1_sign[g]),
      .r_ovf  (s1_ovf[g]),
      .res    (d_nxt[OL +: OUT_W])
    );
  end

  // S1: capture shifted magnitude, sign and ovf
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      s1_ovf   <= '0;
      for (int i = 0; i < N_CH; i++)
        s1_ext[i] <= '0;
    end else if (s1_en) begin
      s1_valid <= io.s_valid;
      if (io.s_valid) begin
        s1_sign <= io.s_sign;
        s1_ovf  <= c_ovf;
        for (int i = 0; i < N_CH; i++)
          s1_ext[i] <= c_ext[i];
      end
    end
  end

  // S2: converted lanes held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= d_nxt;
        s2_sat  <= s1_ovf;
      end
    end
  end

  // count clamped output beats, sticky at all-ones
  always_ff @(posedge clk) begin
    if (rst || sat_clr)
      sat_cnt <= '0;
    else if (s2_valid && io.m_ready &&
             |s2_sat && !(&sat_cnt))
      sat_cnt <= sat_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_sm2tc_pipe.sv
// sm2tc_pipe bench
// random + directed beats vs arithmetic model
module tb_sm2tc_pipe;
  localparam int N_CH  = 2;
  localparam int MAG_W = 10;
  localparam int OUT_W = 12;
  localparam int SH_W  = 2;
  localparam int CNT_W = 16;
  localparam int DW    = N_CH * OUT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             sat_clr;
  logic [CNT_W-1:0] sat_cnt;

  sm2tc_if #(
    .N_CH(N_CH), .MAG_W(MAG_W),
    .OUT_W(OUT_W), .SH_W(SH_W)
  ) sif ();

  sm2tc_pipe #(
    .N_CH(N_CH), .MAG_W(MAG_W), .OUT_W(OUT_W),
    .SH_W(SH_W), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io      (sif),
    .sat_clr (sat_clr),
    .sat_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0]   d;
    logic [N_CH-1:0] s;
    int              t;
  } beat_t;

  beat_t q[$];
  int    sc = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;

  function automatic beat_t model(
    input logic [N_CH*MAG_W-1:0] mag,
    input logic [N_CH-1:0] sg,
    input logic [SH_W-1:0] sh,
    input int t);
    beat_t  b;
    longint v, lo, hi;
    lo = -(longint'(1) << (OUT_W - 1));
    hi = -lo - 1;
    b.t = t;
    b.s = '0;
    b.d = '0;
    for (int i = 0; i < N_CH; i++) begin
      v = longint'(mag[i*MAG_W +: MAG_W]);
      v = v * (longint'(1) << sh);
      if (sg[i]) v = -v;
      if (v > hi) begin
        v = hi; b.s[i] = 1'b1;
      end else if (v < lo) begin
        v = lo; b.s[i] = 1'b1;
      end
      b.d[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic  ev, er;
    beat_t b;
    if (mon_en) begin
      ev = (q.size() > 0) && (cyc - q[0].t >= 2);
      er = !(q.size() == 2 && !sif.m_ready);
      chk("s_ready", 64'(sif.s_ready), 64'(er));
      chk("m_valid", 64'(sif.m_valid), 64'(ev));
      chk("sat_cnt", 64'(sat_cnt), 64'(sc));
      if (ev) begin
        chk("m_data", 64'(sif.m_data), 64'(q[0].d));
        chk("m_sat", 64'(sif.m_sat), 64'(q[0].s));
      end
      if (rst) begin
        q.delete();
        sc = 0;
      end else begin
        if (ev && sif.m_ready) begin
          b = q.pop_front();
          if (!sat_clr && |b.s && sc != 65535)
            sc++;
        end
        if (sat_clr) sc = 0;
        if (sif.s_valid && er)
          q.push_back(model(sif.s_mag, sif.s_sign,
                            sif.shift_amt, cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int m0, input int g0,
                      input int m1, input int g1,
                      input int sh);
    sif.s_valid   = 1'b1;
    sif.s_mag     = {MAG_W'(m1), MAG_W'(m0)};
    sif.s_sign    = {1'(g1), 1'(g0)};
    sif.shift_amt = SH_W'(sh);
  endtask

  task automatic idle();
    sif.s_valid = 1'b0;
  endtask

  logic [DW-1:0] e;
  int            k, n;
  logic          acc;

  initial begin
    rst = 1'b1;
    sat_clr = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_mag = '0;
    sif.s_sign = '0;
    sif.shift_amt = '0;
    sif.m_ready = 1'b1;
    step();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_m_data", 64'(sif.m_data), 64'(0));
    chk("rst_m_sat", 64'(sif.m_sat), 64'(0));
    step();
    rst = 1'b0;

    // basic conversion
    beat(1023, 0, 1023, 1, 1);
    step();
    idle();
    step();
    @(negedge clk);
    e = {12'h802, 12'h7FE};
    chk("t1_data", 64'(sif.m_data), 64'(e));
    chk("t1_sat", 64'(sif.m_sat), 64'(0));
    step();

    // saturation and exact MIN
    beat(600, 0, 512, 1, 2);
    step();
    idle();
    step();
    @(negedge clk);
    e = {12'h800, 12'h7FF};
    chk("t2_data", 64'(sif.m_data), 64'(e));
    chk("t2_sat", 64'(sif.m_sat), 64'(2'b01));
    step();
    @(negedge clk);
    chk("t2_cnt", 64'(sat_cnt), 64'(1));

    // negative zero, shift 0
    step();
    beat(0, 1, 5, 1, 0);
    step();
    idle();
    step();
    @(negedge clk);
    e = {12'hFFB, 12'h000};
    chk("t3_data", 64'(sif.m_data), 64'(e));
    chk("t3_sat", 64'(sif.m_sat), 64'(0));
    step();

    // backpressure stream of 8 beats
    k = 0;
    n = 0;
    while (k < 8 && n < 200) begin
      beat(k * 100 + 7, k % 2, 1023 - k * 50,
           (k + 1) % 2, k % 4);
      sif.m_ready = (n % 4 == 0) || (n % 4 == 3);
      @(negedge clk);
      acc = sif.s_ready;
      step();
      if (acc) k++;
      n++;
    end
    chk("t4_sent", 64'(k), 64'(8));
    idle();
    sif.m_ready = 1'b1;
    repeat (4) step();
    chk("t4_drain", 64'(q.size()), 64'(0));

    // reset with two beats buffered
    sif.m_ready = 1'b0;
    beat(1023, 0, 700, 1, 3);
    step();
    beat(3, 1, 9, 0, 1);
    step();
    idle();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_m_valid", 64'(sif.m_valid), 64'(0));
    chk("t6_m_data", 64'(sif.m_data), 64'(0));
    chk("t6_s_ready", 64'(sif.s_ready), 64'(1));
    chk("t6_cnt", 64'(sat_cnt), 64'(0));
    sif.m_ready = 1'b1;
    repeat (5) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sif.s_valid   = ($urandom % 4) != 0;
      sif.s_mag     = (N_CH*MAG_W)'($urandom);
      sif.s_sign    = N_CH'($urandom);
      sif.shift_amt = SH_W'($urandom);
      sif.m_ready   = ($urandom % 3) != 0;
      sat_clr       = ($urandom % 16) == 0;
      step();
    end
    idle();
    sat_clr = 1'b0;
    sif.m_ready = 1'b1;
    repeat (4) step();
    chk("rnd_drain", 64'(q.size()), 64'(0));

    // counter sticks at all-ones
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    beat(1023, 0, 1023, 1, 3);
    repeat (65536) step();
    idle();
    repeat (3) step();
    @(negedge clk);
    chk("t5_hold", 64'(sat_cnt), 64'(16'hFFFF));

    // clear wins over a counting transfer
    step();
    beat(1023, 0, 1, 0, 3);
    step();
    idle();
    step();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr", 64'(sat_cnt), 64'(0));
    repeat (3) step();
    chk("end_drain", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
